// File: rtl/uno_sched.sv
// Unary-op (div/exp/log) sequencer: drives the scale generator, captures the scale, runs PE iterations, returns acc_i.
// Latency: response 3+N+PE_LAT cycles after accept (N = op iteration count); rejected requests respond 1 cycle after accept.
// Backpressure: one request in flight; req_ready only in IDLE; response held stable in DONE until rsp_ready.
module uno_sched #(
  parameter int MUL_BW   = 16,
  parameter int CNT_BW   = 4,
  parameter int DIV_ITER = 8,
  parameter int EXP_ITER = 6,
  parameter int LOG_ITER = 8,
  parameter int PE_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [MUL_BW-1:0] req_x,
  input  logic [MUL_BW-1:0] req_y,
  // scale generator
  output logic [1:0]        uno_op,
  output logic [MUL_BW-1:0] uno_x,
  output logic [MUL_BW-1:0] uno_y,
  input  logic [MUL_BW-1:0] scale_i,
  // PE control
  output logic [MUL_BW-1:0] pe_scale,
  output logic              pe_clr,
  output logic              pe_en,
  output logic [CNT_BW-1:0] pe_iter,
  input  logic [MUL_BW-1:0] acc_i,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [MUL_BW-1:0] rsp_data,
  output logic [1:0]        rsp_op,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCALE = 3'd1,
    CAPT  = 3'd2,
    ITER  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_GEMM = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_EXP  = 2'b10;
  localparam logic [1:0] OP_LOG  = 2'b11;

  // Iteration counts are stored as "last index" so N = 2^CNT_BW still fits the counter.
  localparam logic [CNT_BW-1:0] DIV_LAST = CNT_BW'(DIV_ITER - 1);
  localparam logic [CNT_BW-1:0] EXP_LAST = CNT_BW'(EXP_ITER - 1);
  localparam logic [CNT_BW-1:0] LOG_LAST = CNT_BW'(LOG_ITER - 1);

  localparam int DL_BW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [DL_BW-1:0] DRAIN_LAST = DL_BW'(PE_LAT - 1);

  state_t            state_q,    state_d;
  logic [1:0]        op_q,       op_d;
  logic [1:0]        uno_op_q,   uno_op_d;
  logic [MUL_BW-1:0] uno_x_q,    uno_x_d;
  logic [MUL_BW-1:0] uno_y_q,    uno_y_d;
  logic [CNT_BW-1:0] last_q,     last_d;
  logic [CNT_BW-1:0] cnt_q,      cnt_d;
  logic [DL_BW-1:0]  dcnt_q,     dcnt_d;
  logic [MUL_BW-1:0] pe_scale_q, pe_scale_d;
  logic [MUL_BW-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_op_q,   rsp_op_d;
  logic              rsp_err_q,  rsp_err_d;

  logic              accept;
  logic              req_bad;
  logic [CNT_BW-1:0] req_last;

  // Classify the incoming request: gemm never belongs here, log needs a strictly positive argument.
  always_comb begin
    req_bad = 1'b0;
    if (req_op == OP_GEMM) begin
      req_bad = 1'b1;
    end else if (req_op == OP_LOG) begin
      req_bad = req_x[MUL_BW-1] || (req_x == '0);
    end
    case (req_op)
      OP_DIV:  req_last = DIV_LAST;
      OP_EXP:  req_last = EXP_LAST;
      OP_LOG:  req_last = LOG_LAST;
      default: req_last = DIV_LAST;
    endcase
  end

  // Next-state and Moore outputs of the sequencer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    uno_op_d   = uno_op_q;
    uno_x_d    = uno_x_q;
    uno_y_d    = uno_y_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    pe_scale_d = pe_scale_q;
    rsp_data_d = rsp_data_q;
    rsp_op_d   = rsp_op_q;
    rsp_err_d  = rsp_err_q;

    req_ready  = 1'b0;
    pe_clr     = 1'b0;
    pe_en      = 1'b0;
    pe_iter    = '0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) begin
          op_d    = req_op;
          uno_x_d = req_x;
          uno_y_d = req_y;
          last_d  = req_last;
          if (req_bad) begin
            // Rejected: keep the scale generator idle and answer immediately.
            uno_op_d   = OP_GEMM;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            rsp_op_d   = req_op;
            state_d    = DONE;
          end else begin
            uno_op_d = req_op;
            state_d  = SCALE;
          end
        end
      end
      SCALE: begin
        // Scale generator registers uno_* during this cycle.
        state_d = CAPT;
      end
      CAPT: begin
        pe_clr     = 1'b1;
        pe_scale_d = scale_i;
        cnt_d      = '0;
        state_d    = ITER;
      end
      ITER: begin
        pe_en   = 1'b1;
        pe_iter = cnt_q;
        if (cnt_q == last_q) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_BW'(1);
        end
      end
      DRAIN: begin
        // Wait for the PE pipeline to settle after the last enable.
        if (dcnt_q == DRAIN_LAST) begin
          rsp_data_d = acc_i;
          rsp_err_d  = 1'b0;
          rsp_op_d   = op_q;
          state_d    = DONE;
        end else begin
          dcnt_d = dcnt_q + DL_BW'(1);
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          uno_op_d = OP_GEMM;
          state_d  = IDLE;
        end
      end
      default: begin
        uno_op_d = OP_GEMM;
        state_d  = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      uno_op_q   <= '0;
      uno_x_q    <= '0;
      uno_y_q    <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      pe_scale_q <= '0;
      rsp_data_q <= '0;
      rsp_op_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      uno_op_q   <= uno_op_d;
      uno_x_q    <= uno_x_d;
      uno_y_q    <= uno_y_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      pe_scale_q <= pe_scale_d;
      rsp_data_q <= rsp_data_d;
      rsp_op_q   <= rsp_op_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign uno_op   = uno_op_q;
  assign uno_x    = uno_x_q;
  assign uno_y    = uno_y_q;
  assign pe_scale = pe_scale_q;
  assign rsp_data = rsp_data_q;
  assign rsp_op   = rsp_op_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != IDLE);

`ifndef SYNTHESIS
  // A handshake can only complete in IDLE.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      assert (state_q == IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_uno_sched.sv
// Directed bench for uno_sched: per-cycle control checks, data capture, stalls, errors, mid-op reset, back-to-back.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point.
// acc_i/scale_i carry the relative cycle number so the capture cycle is observable.
module tb_uno_sched;
  localparam int MUL_BW = 16;
  localparam int CNT_BW = 4;
  localparam int PE_LAT = 1;
  localparam logic [15:0] ACC_BASE = 16'hA000;
  localparam logic [15:0] SC_BASE  = 16'h5000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [1:0]        req_op;
  logic [MUL_BW-1:0] req_x, req_y;
  logic [1:0]        uno_op;
  logic [MUL_BW-1:0] uno_x, uno_y, scale_i, pe_scale, acc_i, rsp_data;
  logic              pe_clr, pe_en;
  logic [CNT_BW-1:0] pe_iter;
  logic              rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]        rsp_op;

  int checks = 0;
  int passes = 0;
  int k = 0;

  always #5 clk = ~clk;

  uno_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .uno_op(uno_op), .uno_x(uno_x), .uno_y(uno_y), .scale_i(scale_i),
    .pe_scale(pe_scale), .pe_clr(pe_clr), .pe_en(pe_en), .pe_iter(pe_iter),
    .acc_i(acc_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
  );

  // Control view: {req_ready, busy, pe_clr, pe_en, pe_iter, rsp_valid, uno_op}
  wire [10:0] ctl = {req_ready, busy, pe_clr, pe_en, pe_iter, rsp_valid, uno_op};

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    acc_i   = ACC_BASE + 16'(k);
    scale_i = SC_BASE + 16'(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_x = '0; req_y = '0;
    rsp_ready = 1'b0; acc_i = ACC_BASE; scale_i = SC_BASE;
    #3;
    checks++;
    if (ctl !== 11'b10_0_0_0000_0_00) $display("FAIL reset_ctl: got %b want %b", ctl, 11'b10_0_0_0000_0_00);
    else passes++;
    checks++;
    if ({uno_x, uno_y, pe_scale, rsp_data, rsp_op, rsp_err} !== '0)
      $display("FAIL reset_data: got x=%h y=%h sc=%h d=%h op=%b err=%b want all 0",
               uno_x, uno_y, pe_scale, rsp_data, rsp_op, rsp_err);
    else passes++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_valid_op(input string nm, input logic [1:0] op, input logic [15:0] x,
                               input logic [15:0] y, input int n, input int stall);
    int rv;
    logic [10:0] exp_ctl;
    logic [15:0] exp_data;
    logic en;
    rv = 3 + n + PE_LAT;
    exp_data = ACC_BASE + 16'(rv - 1);
    k = 0; acc_i = ACC_BASE; scale_i = SC_BASE;
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y; rsp_ready = (stall == 0);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL %s accept_ready: got %b want 1", nm, req_ready);
    else passes++;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= rv; c++) begin
      en = (c >= 3) && (c <= 2 + n);
      exp_ctl = {1'b0, 1'b1, (c == 2), en, (en ? CNT_BW'(c - 3) : CNT_BW'(0)), (c == rv), op};
      checks++;
      if (ctl !== exp_ctl) $display("FAIL %s ctl cycle %0d: got %b want %b", nm, c, ctl, exp_ctl);
      else passes++;
      if (c == 3) begin
        checks++;
        if ({pe_scale, uno_x, uno_y} !== {SC_BASE + 16'd2, x, y})
          $display("FAIL %s operands: got sc=%h x=%h y=%h want sc=%h x=%h y=%h",
                   nm, pe_scale, uno_x, uno_y, SC_BASE + 16'd2, x, y);
        else passes++;
      end
      if (c < rv) step();
    end
    checks++;
    if ({rsp_data, rsp_op, rsp_err} !== {exp_data, op, 1'b0})
      $display("FAIL %s response: got d=%h op=%b err=%b want d=%h op=%b err=0",
               nm, rsp_data, rsp_op, rsp_err, exp_data, op);
    else passes++;
    for (int s = 1; s <= stall; s++) begin
      step();
      checks++;
      if ({ctl, rsp_data, uno_x, uno_y} !== {1'b0, 1'b1, 2'b00, 4'd0, 1'b1, op, exp_data, x, y})
        $display("FAIL %s stall %0d: got ctl=%b d=%h want ctl=%b d=%h",
                 nm, s, ctl, rsp_data, {1'b0, 1'b1, 2'b00, 4'd0, 1'b1, op}, exp_data);
      else passes++;
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (ctl !== 11'b10_0_0_0000_0_00) $display("FAIL %s idle_after: got %b want %b", nm, ctl, 11'b10_0_0_0000_0_00);
    else passes++;
  endtask

  task automatic test_error(input string nm, input logic [1:0] op, input logic [15:0] x);
    k = 0;
    req_valid = 1'b1; req_op = op; req_x = x; req_y = 16'h1234; rsp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL %s accept_ready: got %b want 1", nm, req_ready);
    else passes++;
    step();
    req_valid = 1'b0;
    checks++;
    if (ctl !== 11'b01_0_0_0000_1_00) $display("FAIL %s err_ctl: got %b want %b", nm, ctl, 11'b01_0_0_0000_1_00);
    else passes++;
    checks++;
    if ({rsp_err, rsp_op, rsp_data, uno_x} !== {1'b1, op, 16'h0000, x})
      $display("FAIL %s err_rsp: got err=%b op=%b d=%h x=%h want err=1 op=%b d=0000 x=%h",
               nm, rsp_err, rsp_op, rsp_data, uno_x, op, x);
    else passes++;
    step();
    checks++;
    if (ctl !== 11'b10_0_0_0000_0_00) $display("FAIL %s idle_after: got %b want %b", nm, ctl, 11'b10_0_0_0000_0_00);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int seen;
    k = 0;
    req_valid = 1'b1; req_op = 2'b10; req_x = 16'h0400; req_y = 16'h0000; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    while (k < 6) step();
    checks++;
    if ({pe_en, pe_iter} !== {1'b1, 4'd3}) $display("FAIL rst_mid precond: got en=%b iter=%0d want en=1 iter=3", pe_en, pe_iter);
    else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 11'b10_0_0_0000_0_00) $display("FAIL rst_mid ctl: got %b want %b", ctl, 11'b10_0_0_0000_0_00);
    else passes++;
    checks++;
    if ({uno_x, uno_y, pe_scale, rsp_data, rsp_op, rsp_err} !== '0)
      $display("FAIL rst_mid data: got x=%h y=%h sc=%h d=%h op=%b err=%b want all 0",
               uno_x, uno_y, pe_scale, rsp_data, rsp_op, rsp_err);
    else passes++;
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      step();
      if (rsp_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL rst_mid no_rsp: got %0d active cycles want 0", seen);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int bad;
    int got_cyc;
    k = 0;
    req_valid = 1'b1; req_op = 2'b10; req_x = 16'h0400; req_y = 16'h0000; rsp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL b2b accept_ready: got %b want 1", req_ready);
    else passes++;
    step();
    req_x = 16'h0200;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      if (req_ready !== 1'b0) bad++;
      if (c < 10) step();
    end
    checks++;
    if (bad !== 0) $display("FAIL b2b ready_low: got %0d ready cycles want 0", bad);
    else passes++;
    checks++;
    if (rsp_valid !== 1'b1) $display("FAIL b2b first_rsp: got rsp_valid=%b in cycle 10 want 1", rsp_valid);
    else passes++;
    step();
    checks++;
    if (ctl !== 11'b10_0_0_0000_0_00) $display("FAIL b2b cycle11: got %b want %b", ctl, 11'b10_0_0_0000_0_00);
    else passes++;
    step();
    req_valid = 1'b0;
    checks++;
    if ({busy, uno_op, uno_x} !== {1'b1, 2'b10, 16'h0200})
      $display("FAIL b2b second_accept: got busy=%b op=%b x=%h want busy=1 op=10 x=0200", busy, uno_op, uno_x);
    else passes++;
    got_cyc = -1;
    for (int g = 0; g < 30; g++) begin
      if (rsp_valid === 1'b1) begin
        got_cyc = k;
        break;
      end
      step();
    end
    checks++;
    if ({32'(got_cyc), rsp_data} !== {32'd21, ACC_BASE + 16'd20})
      $display("FAIL b2b second_rsp: got cycle=%0d d=%h want cycle=21 d=%h", got_cyc, rsp_data, ACC_BASE + 16'd20);
    else passes++;
    step();
    checks++;
    if (ctl !== 11'b10_0_0_0000_0_00) $display("FAIL b2b idle_after: got %b want %b", ctl, 11'b10_0_0_0000_0_00);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_valid_op("exp", 2'b10, 16'h0400, 16'h0000, 6, 0);
    test_valid_op("div_stall", 2'b01, 16'h0800, 16'h0C00, 8, 5);
    test_error("gemm", 2'b00, 16'h0400);
    test_error("log_neg", 2'b11, 16'hFC00);
    test_error("log_zero", 2'b11, 16'h0000);
    test_valid_op("log", 2'b11, 16'h0400, 16'h0000, 8, 0);
    test_reset_mid();
    test_valid_op("exp_after_rst", 2'b10, 16'h0400, 16'h0100, 6, 0);
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
